ble_cmd_rx: RTL

Serial command front end for the Segway. It receives 8N1 UART bytes from the BLE module on `RX` and decodes the go/stop commands. It owns the rider-authorisation state machine that drives `pwr_up` into the balance controller and steering-enable logic. It sits directly downstream of the bench-side `uart_tx` command source and upstream of every block gated by `pwr_up`.

---
 rtl/seg_cmd_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 132 +++++++++++++
 rtl/ble_cmd_rx.sv | 62 ++++++
 3 files changed

// File: rtl/seg_cmd_pkg.sv
// Shared types and defaults for the BLE command receiver.
package seg_cmd_pkg;

  localparam int         BAUD_DIV_DEFAULT = 2604;
  localparam logic [7:0] CMD_GO_DEFAULT   = 8'h47;
  localparam logic [7:0] CMD_STOP_DEFAULT = 8'h53;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    PWR1 = 2'd1,
    PWR2 = 2'd2
  } auth_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, start-edge detect, receive FSM
// with a down-counting baud timer sampling at mid-bit.
module uart_rx_core
  import seg_cmd_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err
);

  localparam logic [11:0] BAUD_M1 = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  arm_cnt_q;
  logic        start_edge;
  logic        sample;

  rx_state_t   state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;
  logic        unused_shift;

  // The chain resets high, so edge detection waits until real line values
  // have reached the compare flop; a line already low at release is no start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_cnt_q <= 2'd0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      if (arm_cnt_q != 2'd3) arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  assign start_edge   = (arm_cnt_q == 2'd3) && rx_prev_q && !rx_sync_q;
  assign sample       = (baud_q == 12'd0);
  assign unused_shift = shift_q[0];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          baud_d  = HALF_M1;
        end
      end
      START: begin
        if (!sample) begin
          baud_d = baud_q - 12'd1;
        end else if (!rx_sync_q) begin
          state_d = DATA;
          baud_d  = BAUD_M1;
          bit_d   = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!sample) begin
          baud_d = baud_q - 12'd1;
        end else begin
          shift_d = {rx_sync_q, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
          baud_d  = BAUD_M1;
          if (bit_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!sample) begin
          baud_d = baud_q - 12'd1;
        end else begin
          // Leaving at mid-stop-bit lets a following start bit be caught.
          state_d = IDLE;
          bit_d   = 4'd0;
          if (rx_sync_q) begin
            data_d = shift_q[8:1];
            rdy_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 12'd0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      data_q  <= 8'd0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_rdy    = rdy_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/ble_cmd_rx.sv
// BLE command front end: UART receiver plus the rider-authorisation FSM
// that produces pwr_up from go/stop commands and the rider_off sensor.
module ble_cmd_rx
  import seg_cmd_pkg::*;
#(
  parameter int         BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter logic [7:0] CMD_GO   = CMD_GO_DEFAULT,
  parameter logic [7:0] CMD_STOP = CMD_STOP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       pwr_up
);

  auth_state_t auth_q, auth_d;
  logic        pwr_up_q;
  logic        go_rx, stop_rx;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .frame_err (frame_err)
  );

  assign go_rx   = rx_rdy && (rx_data == CMD_GO);
  assign stop_rx = rx_rdy && (rx_data == CMD_STOP);

  always_comb begin
    auth_d = auth_q;
    case (auth_q)
      OFF:  if (go_rx) auth_d = PWR1;
      PWR1: if (stop_rx) auth_d = rider_off ? OFF : PWR2;
      // A go command beats a simultaneous dismount.
      PWR2: begin
        if (go_rx)          auth_d = PWR1;
        else if (rider_off) auth_d = OFF;
      end
      default: auth_d = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auth_q   <= OFF;
      pwr_up_q <= 1'b0;
    end else begin
      auth_q   <= auth_d;
      pwr_up_q <= (auth_d != OFF);
    end
  end

  assign pwr_up = pwr_up_q;

endmodule
